sram_like_arbiter: RTL and testbench
====================================

// Module: sram_like_arbiter
// PURPOSE
//  N-channel SRAM-like request arbiter. It merges NUM_CH SRAM-like masters onto one SRAM-like slave port:
//   - inst fetch, data, and future uncached/TLB refill ports;
//   - same req/addr_ok/data_ok protocol as the core's inst/data ports.
//  It tracks up to MAX_OUTST accepted requests in order and routes each data_ok/rdata back to the owning channel.
//  It sits between mycpu core stages and the single bus bridge.
// PARAMETERS
//  NUM_CH     2   number of master channels, 1..8; channel 0 = index 0 of packed buses
//  ADDR_W     32  address width
//  DATA_W     32  data width; wstrb width = DATA_W/8
//  MAX_OUTST  4   max accepted-but-unanswered requests, power of 2, >=2
//  RR_MODE    1   1 = round-robin arbitration, 0 = fixed priority (highest index wins)
// PORTS
//  clk          in   1                 clock, all state on rising edge
//  reset        in   1                 asynchronous, active-high; clears all state
//  s_req        in   NUM_CH            per-channel request
//  s_wr         in   NUM_CH            per-channel write flag
//  s_size       in   2*NUM_CH          per-channel size (0=byte,1=half,2=word)
//  s_addr       in   ADDR_W*NUM_CH     per-channel address
//  s_wstrb      in   DATA_W/8*NUM_CH   per-channel byte strobes
//  s_wdata      in   DATA_W*NUM_CH     per-channel write data
//  s_addr_ok    out  NUM_CH            one-hot accept to granted channel
//  s_data_ok    out  NUM_CH            one-hot response to owning channel
//  s_rdata      out  DATA_W            response data, broadcast, valid with s_data_ok
//  m_req        out  1                 slave request
//  m_wr         out  1                 granted channel wr
//  m_size       out  2                 granted channel size
//  m_addr       out  ADDR_W            granted channel addr
//  m_wstrb      out  DATA_W/8          granted channel strobes
//  m_wdata      out  DATA_W            granted channel wdata
//  m_addr_ok    in   1                 slave accept
//  m_data_ok    in   1                 slave response, in request order
//  m_rdata      in   DATA_W            slave response data
//  outst_cnt    out  $clog2(MAX_OUTST)+1  current outstanding count
//  err_unexp    out  1                 sticky: m_data_ok seen with no outstanding entry
// BEHAVIOUR
//  Reset values: outst_cnt=0, err_unexp=0, rr pointer=0, lock=0, FIFO empty.
//   m_req, s_addr_ok and s_data_ok read 0 while reset is high.
//  Arbitration is combinational:
//   - If not locked: grant = winner among s_req.
//     RR_MODE=1: first set bit at or after rr pointer, wrapping. RR_MODE=0: highest set index.
//   - If locked: grant = locked channel.
//  m_req = (|s_req or lock) && outst_cnt < MAX_OUTST. m_* payload = granted channel's fields, zero when m_req=0.
//  Lock: set when m_req && !m_addr_ok, storing the grant. Cleared on the handshake m_req && m_addr_ok.
//   Payload to the slave must stay stable until accepted; the grant never switches mid-request.
//  s_addr_ok[grant] = m_addr_ok && m_req. It is combinational; zero added latency on the request path.
//  Handshake: push grant ID into the ID FIFO (depth MAX_OUTST). RR pointer <= grant+1 mod NUM_CH.
//  Response: on m_data_ok with FIFO non-empty:
//   - s_data_ok[head ID]=1 the same cycle;
//   - s_rdata = m_rdata;
//   - pop the FIFO.
//  m_data_ok with FIFO empty: no s_data_ok, err_unexp <= 1. err_unexp is cleared only by reset.
//  Full: when outst_cnt==MAX_OUTST, m_req=0 even if a pop happens the same cycle; the new request waits 1 cycle.
//   A locked request that becomes blocked stays locked.
//  Simultaneous push+pop when not full: outst_cnt unchanged. FIFO pointers wrap modulo MAX_OUTST.
//  A channel whose s_req drops while locked is a protocol violation; behaviour is undefined and not checked.
//  Reset mid-operation: the FIFO is discarded. The slave must be reset in the same cycle; otherwise stale responses set err_unexp.
//  The same channel may have multiple outstanding requests; responses return to it in order.
// TESTING
//  T1 reset: reset=1 with s_req=2'b11, m_addr_ok=1
//     -> m_req=0, s_addr_ok=0, outst_cnt=0, err_unexp=0.
//  T2 RR alternation: NUM_CH=2, RR_MODE=1, both req held, m_addr_ok=1 every cycle, data_ok 2 cycles later
//     -> grants 0,1,0,1 and s_data_ok 01,10,01,10 with matching rdata.
//  T3 lock: ch0 req, addr 0x1000, m_addr_ok low 3 cycles, ch1 raises req in cycle 1
//     -> m_addr stays 0x1000 until accept, then ch1 is granted.
//  T4 full: MAX_OUTST=4, 4 accepts with no data_ok
//     -> outst_cnt=4, m_req=0; one data_ok -> cnt=3, m_req=1 next cycle.
//  T5 fixed priority: RR_MODE=0, both req held
//     -> ch1 granted every cycle, ch0 never granted.
//  T6 unexpected: m_data_ok=1 with cnt=0
//     -> s_data_ok=0, err_unexp=1 and held until reset.

Source files
------------

// File: rtl/sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_arbiter
// Brief    : Merges NUM_CH SRAM-like masters onto one SRAM-like slave and
//            routes in-order responses back to the owning channel.
// Revision : 1.0 - initial release
// ============================================================================
module sram_like_arbiter #(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4,
    parameter int RR_MODE   = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CH-1:0]              s_req,
    input  logic [NUM_CH-1:0]              s_wr,
    input  logic [2*NUM_CH-1:0]            s_size,
    input  logic [ADDR_W*NUM_CH-1:0]       s_addr,
    input  logic [DATA_W/8*NUM_CH-1:0]     s_wstrb,
    input  logic [DATA_W*NUM_CH-1:0]       s_wdata,
    output logic [NUM_CH-1:0]              s_addr_ok,
    output logic [NUM_CH-1:0]              s_data_ok,
    output logic [DATA_W-1:0]              s_rdata,
    output logic                           m_req,
    output logic                           m_wr,
    output logic [1:0]                     m_size,
    output logic [ADDR_W-1:0]              m_addr,
    output logic [DATA_W/8-1:0]            m_wstrb,
    output logic [DATA_W-1:0]              m_wdata,
    input  logic                           m_addr_ok,
    input  logic                           m_data_ok,
    input  logic [DATA_W-1:0]              m_rdata,
    output logic [$clog2(MAX_OUTST):0]     outst_cnt,
    output logic                           err_unexp
);

    localparam int c_CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_PTR_W = $clog2(MAX_OUTST);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_STB_W = DATA_W / 8;

    logic [c_CH_W-1:0]  rr_q, rr_d;
    logic               lock_q, lock_d;
    logic [c_CH_W-1:0]  lock_id_q, lock_id_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [c_PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic               err_q, err_d;
    logic [c_CH_W-1:0]  fifo_q [MAX_OUTST];

    logic [c_CH_W-1:0]  w_win;
    logic [c_CH_W-1:0]  w_grant;
    logic [c_CH_W-1:0]  w_head;
    logic               w_full;
    logic               w_mreq;
    logic               w_hs;
    logic               w_pop;
    int                 w_sel;

    generate
        if (RR_MODE != 0) begin : g_rr_arb
            always_comb begin
                logic w_found;
                int   w_idx;
                w_win   = '0;
                w_found = 1'b0;
                w_idx   = 0;
                for (int i = 0; i < NUM_CH; i++) begin
                    w_idx = (int'(rr_q) + i) % NUM_CH;
                    if (!w_found && s_req[w_idx]) begin
                        w_win   = c_CH_W'(w_idx);
                        w_found = 1'b1;
                    end
                end
            end
        end else begin : g_fix_arb
            // Last set bit overwrites earlier ones, so the highest index wins.
            always_comb begin
                w_win = '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (s_req[i]) w_win = c_CH_W'(i);
                end
            end
        end
    endgenerate

    always_comb begin
        w_grant = lock_q ? lock_id_q : w_win;
        w_sel   = int'(w_grant);
        w_full  = (cnt_q == c_CNT_W'(MAX_OUTST));
        w_mreq  = ((|s_req) || lock_q) && !w_full && !reset;
        w_hs    = w_mreq && m_addr_ok;
        w_pop   = m_data_ok && (cnt_q != '0) && !reset;
        w_head  = fifo_q[rd_q];
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            assign s_addr_ok[g] = w_hs  && (w_grant == c_CH_W'(g));
            assign s_data_ok[g] = w_pop && (w_head  == c_CH_W'(g));
        end
    endgenerate

    assign m_req     = w_mreq;
    assign m_wr      = w_mreq ? s_wr[w_sel] : 1'b0;
    assign m_size    = w_mreq ? s_size[w_sel*2 +: 2] : 2'b00;
    assign m_addr    = w_mreq ? s_addr[w_sel*ADDR_W +: ADDR_W] : '0;
    assign m_wstrb   = w_mreq ? s_wstrb[w_sel*c_STB_W +: c_STB_W] : '0;
    assign m_wdata   = w_mreq ? s_wdata[w_sel*DATA_W +: DATA_W] : '0;
    assign s_rdata   = m_rdata;
    assign outst_cnt = cnt_q;
    assign err_unexp = err_q;

    always_comb begin
        rr_d      = rr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        err_d     = err_q;
        if (w_hs) begin
            wr_d   = wr_q + 1'b1;
            lock_d = 1'b0;
            rr_d   = (w_grant == c_CH_W'(NUM_CH - 1)) ? '0 : w_grant + 1'b1;
        end else if (w_mreq) begin
            // Hold the grant so the slave sees a stable payload until accepted.
            lock_d    = 1'b1;
            lock_id_d = w_grant;
        end
        if (w_pop) rd_d = rd_q + 1'b1;
        if (w_hs && !w_pop) cnt_d = cnt_q + 1'b1;
        else if (!w_hs && w_pop) cnt_d = cnt_q - 1'b1;
        if (m_data_ok && (cnt_q == '0)) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q      <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            cnt_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs) fifo_q[wr_q] <= w_grant;
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_like_arbiter
// Brief    : Directed bench for sram_like_arbiter (round-robin and fixed).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  s_req;
    logic [1:0]  s_wr;
    logic [3:0]  s_size;
    logic [63:0] s_addr;
    logic [7:0]  s_wstrb;
    logic [63:0] s_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;
    logic        fp_addr_ok, fp_data_ok;

    logic [1:0]  s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic [2:0]  outst_cnt;
    logic        err_unexp;

    logic [1:0]  fp_s_addr_ok, fp_s_data_ok;
    logic [31:0] fp_s_rdata;
    logic        fp_m_req, fp_m_wr;
    logic [1:0]  fp_m_size;
    logic [31:0] fp_m_addr, fp_m_wdata;
    logic [3:0]  fp_m_wstrb;
    logic [2:0]  fp_outst_cnt;
    logic        fp_err_unexp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(4), .RR_MODE(1)) u_dut (
        .clk(clk), .reset(reset), .s_req(s_req), .s_wr(s_wr), .s_size(s_size),
        .s_addr(s_addr), .s_wstrb(s_wstrb), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_wstrb(m_wstrb), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok),
        .m_data_ok(m_data_ok), .m_rdata(m_rdata), .outst_cnt(outst_cnt),
        .err_unexp(err_unexp)
    );

    sram_like_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(4), .RR_MODE(0)) u_dut_fp (
        .clk(clk), .reset(reset), .s_req(s_req), .s_wr(s_wr), .s_size(s_size),
        .s_addr(s_addr), .s_wstrb(s_wstrb), .s_wdata(s_wdata),
        .s_addr_ok(fp_s_addr_ok), .s_data_ok(fp_s_data_ok), .s_rdata(fp_s_rdata),
        .m_req(fp_m_req), .m_wr(fp_m_wr), .m_size(fp_m_size), .m_addr(fp_m_addr),
        .m_wstrb(fp_m_wstrb), .m_wdata(fp_m_wdata), .m_addr_ok(fp_addr_ok),
        .m_data_ok(fp_data_ok), .m_rdata(m_rdata), .outst_cnt(fp_outst_cnt),
        .err_unexp(fp_err_unexp)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        step();
        reset = 1'b1; s_req = 2'b00; m_addr_ok = 1'b0; m_data_ok = 1'b0;
        fp_addr_ok = 1'b0; fp_data_ok = 1'b0;
        #1;
        check("rst_cnt", 64'(outst_cnt), 64'd0);
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; s_req = 2'b11; m_addr_ok = 1'b1; m_data_ok = 1'b1;
        fp_addr_ok = 1'b1; fp_data_ok = 1'b0; m_rdata = '0;
        s_wr    = 2'b10;
        s_size  = {2'd1, 2'd2};
        s_addr  = {32'h0000_2000, 32'h0000_1000};
        s_wstrb = {4'h3, 4'hF};
        s_wdata = {32'h0000_00B1, 32'h0000_00A0};

        // T1: reset held with requests and slave strobes active
        step(); step(); #1;
        check("t1_m_req", 64'(m_req), 64'd0);
        check("t1_addr_ok", 64'(s_addr_ok), 64'd0);
        check("t1_data_ok", 64'(s_data_ok), 64'd0);
        check("t1_cnt", 64'(outst_cnt), 64'd0);
        check("t1_err", 64'(err_unexp), 64'd0);
        step();
        reset = 1'b0; s_req = 2'b00; m_data_ok = 1'b0; m_addr_ok = 1'b0; fp_addr_ok = 1'b0;

        // T2: round-robin alternation, responses two cycles behind
        for (int k = 0; k < 6; k++) begin
            step();
            s_req     = (k < 4) ? 2'b11 : 2'b00;
            m_addr_ok = 1'b1;
            m_data_ok = (k >= 2);
            m_rdata   = 32'h100 + 32'(k);
            #1;
            if (k < 4) begin
                check("t2_grant", 64'(s_addr_ok), (k % 2 == 0) ? 64'd1 : 64'd2);
                check("t2_addr", 64'(m_addr), (k % 2 == 0) ? 64'h1000 : 64'h2000);
            end
            if (k == 1) begin
                check("t2_wdata", 64'(m_wdata), 64'hB1);
                check("t2_wr", 64'(m_wr), 64'd1);
                check("t2_size", 64'(m_size), 64'd1);
                check("t2_wstrb", 64'(m_wstrb), 64'h3);
            end
            if (k >= 2) begin
                check("t2_data_ok", 64'(s_data_ok), (k % 2 == 0) ? 64'd1 : 64'd2);
                check("t2_rdata", 64'(s_rdata), 64'h100 + 64'(k));
            end
        end
        step();
        m_data_ok = 1'b0; m_addr_ok = 1'b0;
        #1;
        check("t2_cnt_end", 64'(outst_cnt), 64'd0);
        check("t2_mreq_idle", 64'(m_req), 64'd0);

        // Move the round-robin pointer to ch1 so only the lock keeps ch0 granted
        s_req = 2'b01; m_addr_ok = 1'b1;
        #1;
        check("pre_grant", 64'(s_addr_ok), 64'd1);
        step();
        s_req = 2'b00; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h55;
        #1;
        check("pre_data_ok", 64'(s_data_ok), 64'd1);
        step();
        m_data_ok = 1'b0;

        // T3: lock holds ch0 for three stalled cycles while ch1 is requesting
        for (int k = 0; k < 4; k++) begin
            s_req     = (k == 0) ? 2'b01 : 2'b11;
            m_addr_ok = (k == 3);
            #1;
            check("t3_mreq", 64'(m_req), 64'd1);
            check("t3_addr", 64'(m_addr), 64'h1000);
            check("t3_addr_ok", 64'(s_addr_ok), (k == 3) ? 64'd1 : 64'd0);
            step();
        end
        s_req = 2'b10; m_addr_ok = 1'b1;
        #1;
        check("t3_ch1_grant", 64'(s_addr_ok), 64'd2);
        check("t3_ch1_addr", 64'(m_addr), 64'h2000);
        step();
        s_req = 2'b00; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h66;
        #1;
        check("t3_rsp0", 64'(s_data_ok), 64'd1);
        step();
        #1;
        check("t3_rsp1", 64'(s_data_ok), 64'd2);
        step();
        m_data_ok = 1'b0;
        #1;
        check("t3_cnt_end", 64'(outst_cnt), 64'd0);

        // T4: four accepts fill the tracker; a pop frees it one cycle later
        for (int k = 0; k < 4; k++) begin
            s_req = 2'b11; m_addr_ok = 1'b1;
            step();
        end
        m_addr_ok = 1'b0;
        #1;
        check("t4_cnt_full", 64'(outst_cnt), 64'd4);
        check("t4_mreq_full", 64'(m_req), 64'd0);
        check("t4_addr_zero", 64'(m_addr), 64'd0);
        m_data_ok = 1'b1; m_rdata = 32'h77;
        #1;
        check("t4_mreq_pop", 64'(m_req), 64'd0);
        check("t4_rsp", 64'(s_data_ok), 64'd1);
        check("t4_rdata", 64'(s_rdata), 64'h77);
        step();
        m_data_ok = 1'b0;
        #1;
        check("t4_cnt_after", 64'(outst_cnt), 64'd3);
        check("t4_mreq_after", 64'(m_req), 64'd1);
        pulse_reset();

        // T5: fixed priority always picks ch1
        for (int k = 0; k < 5; k++) begin
            s_req = 2'b11; fp_addr_ok = 1'b1; fp_data_ok = (k > 0);
            #1;
            check("t5_fp_grant", 64'(fp_s_addr_ok), 64'd2);
            check("t5_fp_addr", 64'(fp_m_addr), 64'h2000);
            step();
        end
        fp_addr_ok = 1'b0; fp_data_ok = 1'b0;
        pulse_reset();

        // T6: unexpected response is dropped and sticks the error flag
        m_data_ok = 1'b1; m_rdata = 32'h99;
        #1;
        check("t6_no_rsp", 64'(s_data_ok), 64'd0);
        step();
        m_data_ok = 1'b0;
        #1;
        check("t6_err_set", 64'(err_unexp), 64'd1);
        step(); step();
        check("t6_err_hold", 64'(err_unexp), 64'd1);
        check("t6_cnt", 64'(outst_cnt), 64'd0);
        pulse_reset();
        #1;
        check("t6_err_clr", 64'(err_unexp), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
